// File: rtl/vga_sync_if.sv
// Bundle of the VGA timing outputs and the colour-switch input shared between
// the sync controller (master) and the character generator (slave).
interface vga_sync_if;
  logic [2:0] sw_rgb;
  logic       p_tick;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixelx;
  logic [9:0] pixely;
  logic [2:0] rgbswitches;
  logic       frame_end;

  modport master (
    input  sw_rgb,
    output p_tick, hsync, vsync, video_on, pixelx, pixely, rgbswitches, frame_end
  );

  modport slave (
    output sw_rgb,
    input  p_tick, hsync, vsync, video_on, pixelx, pixely, rgbswitches, frame_end
  );
endinterface

// File: rtl/vga_sync_controller.sv
// VGA timing master: pixel tick divider, horizontal/vertical scan counters,
// registered hsync/vsync/video_on, and a frame-boundary latch for the colour
// switches so the text colour never changes mid-frame.
module vga_sync_controller #(
  parameter int TICK_DIV  = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS     = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_LO = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic [2:0]       rgb_q, rgb_d;
  logic [2:0]       sw_meta_q, sw_sync_q;
  logic             tick;
  logic             frame_end;

  assign tick      = (div_q == DIV_LAST);
  assign frame_end = tick && (h_q == H_LAST) && (v_q == V_LAST);

  // Next-state scan position; sync/blank decode uses the next position so the
  // registered strobes line up with pixelx/pixely on the same edge.
  always_comb begin
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    h_d        = h_q;
    v_d        = v_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      hsync_d    = !((h_d >= H_SYNC_LO) && (h_d <= H_SYNC_HI));
      vsync_d    = !((v_d >= V_SYNC_LO) && (v_d <= V_SYNC_HI));
      video_on_d = (h_d < H_VIS) && (v_d < V_VIS);
    end
    rgb_d = frame_end ? sw_sync_q : rgb_q;
  end

  // State registers, including the two-flop switch synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      rgb_q      <= 3'b000;
      sw_meta_q  <= 3'b000;
      sw_sync_q  <= 3'b000;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      rgb_q      <= rgb_d;
      sw_meta_q  <= vga.sw_rgb;
      sw_sync_q  <= sw_meta_q;
    end
  end

  assign vga.p_tick      = tick;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.pixelx      = h_q;
  assign vga.pixely      = v_q;
  assign vga.rgbswitches = rgb_q;
  assign vga.frame_end   = frame_end;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Bench for vga_sync_controller using a shrunken raster so whole frames fit
// in a short run: 15 x 10 pixels, 4 clks per pixel, 600 clks per frame.
//   H: visible 0..7, front 8..9, sync 10..12, back 13..14
//   V: visible 0..5, front 6,    sync 7..8,   back 9
module tb_vga_sync_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;

  vga_sync_if vif ();

  vga_sync_controller #(
    .TICK_DIV (4),
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vga  (vif.master)
  );

  always #5 clk = ~clk;

  // Expected snapshot: taken at the falling edge after `cyc` rising edges
  // since the reset release of the given phase.
  typedef struct {
    int         phase;
    int         cyc;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       pt;
    logic       fe;
    logic [2:0] rgb;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   phase    = 0;
  int   cyc      = 0;
  int   fe_count = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge reset) phase = phase + 1;

  function automatic logic [28:0] pack_dut();
    return {vif.pixelx, vif.pixely, vif.hsync, vif.vsync, vif.video_on,
            vif.p_tick, vif.frame_end, vif.rgbswitches};
  endfunction

  function automatic logic [28:0] pack_exp(exp_t e);
    return {e.x, e.y, e.hs, e.vs, e.von, e.pt, e.fe, e.rgb};
  endfunction

  task automatic check(input string name, input logic [28:0] got, input logic [28:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fe=%b rgb=%b required x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fe=%b rgb=%b",
               name, got[28:19], got[18:9], got[8], got[7], got[6], got[5], got[4], got[3:0] & 4'h7,
               want[28:19], want[18:9], want[8], want[7], want[6], want[5], want[4], want[3:0] & 4'h7);
    end
  endtask

  task automatic push(input int ph, input int c, input int x, input int y,
                      input logic hs, input logic vs, input logic von,
                      input logic pt, input logic fe, input logic [2:0] rgb);
    exp_t e;
    e.phase = ph; e.cyc = c; e.x = 10'(x); e.y = 10'(y);
    e.hs = hs; e.vs = vs; e.von = von; e.pt = pt; e.fe = fe; e.rgb = rgb;
    q.push_back(e);
  endtask

  // Monitor: pops each expected snapshot when its cycle comes around.
  always @(negedge clk) begin
    if (!reset) begin
      if (phase == 1 && vif.frame_end) fe_count++;
      while (q.size() > 0 && q[0].phase == phase && q[0].cyc <= cyc) begin
        if (q[0].cyc == cyc) begin
          check($sformatf("ph%0d_cyc%0d", phase, cyc), pack_dut(), pack_exp(q[0]));
        end else begin
          checks++;
          failures++;
          $display("FAIL missed_ph%0d_cyc%0d now=%0d required sample at %0d", phase, q[0].cyc, cyc, q[0].cyc);
        end
        void'(q.pop_front());
      end
    end
  end

  localparam logic [28:0] RESET_VEC = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000};

  initial begin
    vif.sw_rgb = 3'b000;

    repeat (3) @(negedge clk);
    check("reset_state", pack_dut(), RESET_VEC);

    //          ph cyc   x  y  hs vs von pt fe rgb
    push(1,   1,  0, 0, 1, 1, 0, 0, 0, 3'b000);
    push(1,   3,  0, 0, 1, 1, 0, 1, 0, 3'b000);
    push(1,   4,  1, 0, 1, 1, 1, 0, 0, 3'b000);
    push(1,  28,  7, 0, 1, 1, 1, 0, 0, 3'b000);
    push(1,  32,  8, 0, 1, 1, 0, 0, 0, 3'b000);
    push(1,  39,  9, 0, 1, 1, 0, 1, 0, 3'b000);
    push(1,  40, 10, 0, 0, 1, 0, 0, 0, 3'b000);
    push(1,  51, 12, 0, 0, 1, 0, 1, 0, 3'b000);
    push(1,  52, 13, 0, 1, 1, 0, 0, 0, 3'b000);
    push(1,  60,  0, 1, 1, 1, 1, 0, 0, 3'b000);
    push(1, 328,  7, 5, 1, 1, 1, 0, 0, 3'b000);
    push(1, 332,  8, 5, 1, 1, 0, 0, 0, 3'b000);
    push(1, 360,  0, 6, 1, 1, 0, 0, 0, 3'b000);
    push(1, 416, 14, 6, 1, 1, 0, 0, 0, 3'b000);
    push(1, 420,  0, 7, 1, 0, 0, 0, 0, 3'b000);
    push(1, 536, 14, 8, 1, 0, 0, 0, 0, 3'b000);
    push(1, 540,  0, 9, 1, 1, 0, 0, 0, 3'b000);
    push(1, 598, 14, 9, 1, 1, 0, 0, 0, 3'b000);
    push(1, 599, 14, 9, 1, 1, 0, 1, 1, 3'b000);
    push(1, 600,  0, 0, 1, 1, 1, 0, 0, 3'b101);
    push(1,1199, 14, 9, 1, 1, 0, 1, 1, 3'b101);
    push(1,1200,  0, 0, 1, 1, 1, 0, 0, 3'b101);
    push(1,1401,  5, 3, 1, 1, 1, 0, 0, 3'b101);
    #1 reset = 1'b0;

    // Colour change mid-frame, then a glitch that returns before frame end.
    wait (cyc == 100); #1 vif.sw_rgb = 3'b101;
    wait (cyc == 700); #1 vif.sw_rgb = 3'b010;
    wait (cyc == 800); #1 vif.sw_rgb = 3'b101;

    // Asynchronous reset mid-frame, sampled before any further rising edge.
    wait (cyc == 1401);
    @(negedge clk);
    #1 reset = 1'b1;
    #2 check("async_reset", pack_dut(), RESET_VEC);

    checks++;
    if (fe_count != 2) begin
      failures++;
      $display("FAIL frame_end_count got %0d required 2", fe_count);
    end

    repeat (3) @(negedge clk);
    check("reset_hold", pack_dut(), RESET_VEC);

    push(2,  1,  0, 0, 1, 1, 0, 0, 0, 3'b000);
    push(2,  3,  0, 0, 1, 1, 0, 1, 0, 3'b000);
    push(2,  4,  1, 0, 1, 1, 1, 0, 0, 3'b000);
    push(2, 60,  0, 1, 1, 1, 1, 0, 0, 3'b000);
    #1 reset = 1'b0;

    repeat (80) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
